// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared FSM encoding and default sizing for the FIFO round-robin arbiter
package fifo_arb_pkg;
  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_e;
  localparam int NUM_QUEUES_DEF = 4;
  localparam int QUEUE_BITS_DEF = 2;
  localparam int DATA_WIDTH_DEF = 64;
endpackage

// File: rtl/rr_priority_select.sv
// rr_priority_select: first set mask bit at or cyclically after ptr
//   mask  : candidate queues (1 = eligible)
//   ptr   : search start index, must be < NUM_QUEUES
//   valid : any candidate present
//   sel   : chosen queue index
module rr_priority_select
  import fifo_arb_pkg::*;
#(
  parameter int NUM_QUEUES = NUM_QUEUES_DEF,
  parameter int QUEUE_BITS = QUEUE_BITS_DEF
) (
  input  logic [NUM_QUEUES-1:0] mask,
  input  logic [QUEUE_BITS-1:0] ptr,
  output logic                  valid,
  output logic [QUEUE_BITS-1:0] sel
);
  logic [QUEUE_BITS-1:0] idx;
  // scan offsets from farthest to nearest so the nearest hit overwrites the rest
  always_comb begin
    valid = |mask;
    sel = '0;
    idx = '0;
    for (int k = NUM_QUEUES - 1; k >= 0; k--) begin
      idx = QUEUE_BITS'((int'(ptr) + k) % NUM_QUEUES);
      if (mask[idx]) sel = idx;
    end
  end
endmodule

// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: packet-granular round-robin drain of fallthrough FIFOs into one registered stream
//   in_data/in_eop/in_empty : head word, EOP flag and empty flag of each input FIFO
//   in_rd_en                : per-FIFO pop strobe, at most one bit set
//   out_rdy                 : downstream has room (driven from ~nearly_full)
//   out_wr/out_data/out_eop/out_src : registered output word, EOP and source queue
module fifo_rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_QUEUES = NUM_QUEUES_DEF,
  parameter int QUEUE_BITS = QUEUE_BITS_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_QUEUES-1:0]            in_eop,
  input  logic [NUM_QUEUES-1:0]            in_empty,
  output logic [NUM_QUEUES-1:0]            in_rd_en,
  input  logic                             out_rdy,
  output logic                             out_wr,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic                             out_eop,
  output logic [QUEUE_BITS-1:0]            out_src
);
  state_e                state_q, state_d;
  logic [QUEUE_BITS-1:0] cur_q, cur_d, rr_ptr_q, rr_ptr_d, sel;
  logic                  sel_valid, pop, cur_eop;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  out_wr_q, out_wr_d, out_eop_q, out_eop_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [QUEUE_BITS-1:0] out_src_q, out_src_d;

  rr_priority_select #(.NUM_QUEUES(NUM_QUEUES), .QUEUE_BITS(QUEUE_BITS)) u_sel (
    .mask (~in_empty),
    .ptr  (rr_ptr_q),
    .valid(sel_valid),
    .sel  (sel)
  );

  // the locked queue is held until its EOP leaves, so empty or !out_rdy just stalls here
  always_comb begin
    cur_data = in_data[cur_q*DATA_WIDTH +: DATA_WIDTH];
    cur_eop = in_eop[cur_q];
    pop = (state_q == XFER) && !in_empty[cur_q] && out_rdy;
    in_rd_en = NUM_QUEUES'(pop) << cur_q;
    state_d = (state_q == IDLE) ? (sel_valid ? XFER : IDLE) : ((pop && cur_eop) ? IDLE : XFER);
    cur_d = (state_q == IDLE && sel_valid) ? sel : cur_q;
    rr_ptr_d = (pop && cur_eop) ? ((cur_q == QUEUE_BITS'(NUM_QUEUES - 1)) ? '0 : cur_q + 1'b1) : rr_ptr_q;
    out_wr_d = pop;
    out_data_d = pop ? cur_data : out_data_q;
    out_eop_d = pop ? cur_eop : out_eop_q;
    out_src_d = pop ? cur_q : out_src_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cur_q <= '0;
      rr_ptr_q <= '0;
      out_wr_q <= 1'b0;
      out_data_q <= '0;
      out_eop_q <= 1'b0;
      out_src_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      rr_ptr_q <= rr_ptr_d;
      out_wr_q <= out_wr_d;
      out_data_q <= out_data_d;
      out_eop_q <= out_eop_d;
      out_src_q <= out_src_d;
    end
  end

  assign out_wr = out_wr_q;
  assign out_data = out_data_q;
  assign out_eop = out_eop_q;
  assign out_src = out_src_q;
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: directed checks of the FIFO round-robin arbiter
module tb_fifo_rr_arbiter;
  import fifo_arb_pkg::*;
  localparam int NQ = 4, QB = 2, DW = 64, DEPTH = 64, NQ3 = 3;

  logic clk = 1'b0, reset = 1'b1, out_rdy = 1'b1;
  logic [NQ*DW-1:0] in_data;
  logic [NQ-1:0] in_eop, in_empty, in_rd_en;
  logic out_wr, out_eop;
  logic [DW-1:0] out_data;
  logic [QB-1:0] out_src;

  logic [NQ3*DW-1:0] in_data3;
  logic [NQ3-1:0] in_eop3, in_empty3, in_rd_en3;
  logic out_wr3, out_eop3;
  logic [DW-1:0] out_data3;
  logic [QB-1:0] out_src3;

  logic [DW:0] mem [NQ][DEPTH];
  int wp [NQ];
  int rp [NQ];
  int push3 [NQ3];
  int pop3 [NQ3];
  int bad_pops = 0;
  int cyc = 0;
  int n = 0, n3 = 0;
  logic [DW-1:0] lg_data [256];
  logic lg_eop [256];
  logic [QB-1:0] lg_src [256];
  int lg_cyc [256];
  logic [QB-1:0] lg3_src [256];
  logic [DW-1:0] lg3_data [256];
  int asserts = 0, fails = 0;

  fifo_rr_arbiter #(.NUM_QUEUES(NQ), .QUEUE_BITS(QB), .DATA_WIDTH(DW)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_eop(in_eop), .in_empty(in_empty),
    .in_rd_en(in_rd_en), .out_rdy(out_rdy), .out_wr(out_wr), .out_data(out_data),
    .out_eop(out_eop), .out_src(out_src)
  );

  fifo_rr_arbiter #(.NUM_QUEUES(NQ3), .QUEUE_BITS(QB), .DATA_WIDTH(DW)) u_dut3 (
    .clk(clk), .reset(reset), .in_data(in_data3), .in_eop(in_eop3), .in_empty(in_empty3),
    .in_rd_en(in_rd_en3), .out_rdy(1'b1), .out_wr(out_wr3), .out_data(out_data3),
    .out_eop(out_eop3), .out_src(out_src3)
  );

  always #5 clk = ~clk;

  always_comb begin
    in_data = '0;
    in_eop = '0;
    in_empty = '0;
    for (int i = 0; i < NQ; i++) begin
      in_empty[i] = (rp[i] == wp[i]);
      in_data[i*DW +: DW] = mem[i][rp[i] % DEPTH][DW-1:0];
      in_eop[i] = mem[i][rp[i] % DEPTH][DW];
    end
  end

  always_comb begin
    in_data3 = '0;
    in_eop3 = '1;
    in_empty3 = '0;
    for (int i = 0; i < NQ3; i++) begin
      in_empty3[i] = (push3[i] == pop3[i]);
      in_data3[i*DW +: DW] = DW'(100 + i);
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!reset && ($countones(in_rd_en) > 1 || $countones(in_rd_en3) > 1)) bad_pops <= bad_pops + 1;
    for (int i = 0; i < NQ; i++) begin
      if (reset) rp[i] <= wp[i];
      else if (in_rd_en[i]) begin
        rp[i] <= rp[i] + 1;
        if (rp[i] == wp[i]) bad_pops <= bad_pops + 1;
      end
    end
    for (int i = 0; i < NQ3; i++) begin
      if (reset) pop3[i] <= push3[i];
      else if (in_rd_en3[i]) begin
        pop3[i] <= pop3[i] + 1;
        if (pop3[i] == push3[i]) bad_pops <= bad_pops + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (out_wr === 1'b1) begin
      lg_data[n] <= out_data;
      lg_eop[n] <= out_eop;
      lg_src[n] <= out_src;
      lg_cyc[n] <= cyc;
      n <= n + 1;
    end
    if (out_wr3 === 1'b1) begin
      lg3_src[n3] <= out_src3;
      lg3_data[n3] <= out_data3;
      n3 <= n3 + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [DW-1:0] word(input int q, input int p, input int w);
    return {32'hCAFE_0000, 8'(q), 8'(p), 16'(w)};
  endfunction

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int q, input logic [DW-1:0] d, input logic e);
    mem[q][wp[q] % DEPTH] = {e, d};
    wp[q] = wp[q] + 1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    out_rdy = 1'b1;
    repeat (2) tick;
    reset = 1'b0;
  endtask

  task automatic wait_n(input int target, input int limit, input string tag);
    int k = 0;
    while (n < target && k < limit) begin
      tick;
      k++;
    end
    asserts++;
    if (n < target) begin
      fails++;
      $display("FAIL %s timeout: words seen %0d, required %0d", tag, n, target);
    end
  endtask

  task automatic wait_n3(input int target, input int limit, input string tag);
    int k = 0;
    while (n3 < target && k < limit) begin
      tick;
      k++;
    end
    asserts++;
    if (n3 < target) begin
      fails++;
      $display("FAIL %s timeout: words seen %0d, required %0d", tag, n3, target);
    end
  endtask

  task automatic test_reset;
    do_reset;
    asserts += 6;
    if (out_wr !== 1'b0) begin fails++; $display("FAIL reset_out_wr: got %b, want 0", out_wr); end
    if (out_data !== '0) begin fails++; $display("FAIL reset_out_data: got %h, want 0", out_data); end
    if ({out_eop, out_src} !== 3'b000) begin fails++; $display("FAIL reset_eop_src: got %b/%0d, want 0/0", out_eop, out_src); end
    if (in_rd_en !== '0) begin fails++; $display("FAIL reset_rd_en: got %b, want 0", in_rd_en); end
    if (u_dut.state_q !== IDLE) begin fails++; $display("FAIL reset_state: got %0d, want IDLE", u_dut.state_q); end
    if (u_dut.rr_ptr_q !== 2'd0 || u_dut.cur_q !== 2'd0) begin fails++; $display("FAIL reset_ptrs: rr_ptr %0d cur %0d, want 0 0", u_dut.rr_ptr_q, u_dut.cur_q); end
  endtask

  task automatic test_single;
    int b, c;
    b = n;
    c = cyc;
    push(2, word(2, 0, 0), 1'b0);
    push(2, word(2, 0, 1), 1'b0);
    push(2, word(2, 0, 2), 1'b1);
    wait_n(b + 3, 20, "single");
    repeat (3) tick;
    asserts++;
    if (n !== b + 3) begin fails++; $display("FAIL single_count: got %0d words, want 3", n - b); end
    for (int k = 0; k < 3; k++) begin
      asserts++;
      if (lg_data[b+k] !== word(2, 0, k) || lg_src[b+k] !== 2'd2 || lg_eop[b+k] !== (k == 2) || lg_cyc[b+k] !== c + 2 + k)
        begin fails++; $display("FAIL single_word%0d: got data %h src %0d eop %b cyc %0d, want %h 2 %b %0d", k, lg_data[b+k], lg_src[b+k], lg_eop[b+k], lg_cyc[b+k], word(2, 0, k), k == 2, c + 2 + k); end
    end
    asserts++;
    if (u_dut.rr_ptr_q !== 2'd3) begin fails++; $display("FAIL single_rr_ptr: got %0d, want 3", u_dut.rr_ptr_q); end
  endtask

  task automatic test_fairness;
    int b, q, p, gap;
    int qs [3] = '{0, 1, 3};
    do_reset;
    b = n;
    for (int pp = 0; pp < 2; pp++)
      for (int j = 0; j < 3; j++)
        for (int w = 0; w < 2; w++) push(qs[j], word(qs[j], pp, w), w == 1);
    wait_n(b + 12, 100, "fairness");
    repeat (3) tick;
    asserts++;
    if (n !== b + 12) begin fails++; $display("FAIL fair_count: got %0d words, want 12", n - b); end
    for (int k = 0; k < 12; k++) begin
      q = qs[(k / 2) % 3];
      p = k / 6;
      gap = (k % 2 == 0) ? 2 : 1;
      asserts++;
      if (lg_data[b+k] !== word(q, p, k % 2) || lg_src[b+k] !== QB'(q) || lg_eop[b+k] !== (k % 2 == 1))
        begin fails++; $display("FAIL fair_word%0d: got data %h src %0d eop %b, want %h %0d %b", k, lg_data[b+k], lg_src[b+k], lg_eop[b+k], word(q, p, k % 2), q, k % 2 == 1); end
      if (k > 0) begin
        asserts++;
        if (lg_cyc[b+k] - lg_cyc[b+k-1] !== gap) begin fails++; $display("FAIL fair_gap%0d: got %0d cycles, want %0d", k, lg_cyc[b+k] - lg_cyc[b+k-1], gap); end
      end
    end
  endtask

  task automatic test_back_pressure;
    int b;
    do_reset;
    b = n;
    for (int w = 0; w < 4; w++) push(0, word(0, 7, w), w == 3);
    wait_n(b + 1, 20, "bp_first");
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      asserts++;
      if (in_rd_en !== '0) begin fails++; $display("FAIL bp_rd_en%0d: got %b, want 0", i, in_rd_en); end
      tick;
      asserts++;
      if (out_wr !== 1'b0) begin fails++; $display("FAIL bp_out_wr%0d: got %b, want 0", i, out_wr); end
    end
    out_rdy = 1'b1;
    wait_n(b + 4, 20, "bp_resume");
    repeat (3) tick;
    asserts++;
    if (n !== b + 4) begin fails++; $display("FAIL bp_count: got %0d words, want 4", n - b); end
    for (int k = 0; k < 4; k++) begin
      asserts++;
      if (lg_data[b+k] !== word(0, 7, k) || lg_eop[b+k] !== (k == 3))
        begin fails++; $display("FAIL bp_word%0d: got %h eop %b, want %h %b", k, lg_data[b+k], lg_eop[b+k], word(0, 7, k), k == 3); end
    end
  endtask

  task automatic test_underrun;
    int b;
    do_reset;
    b = n;
    push(0, word(0, 3, 0), 1'b0);
    push(0, word(0, 3, 1), 1'b0);
    push(1, word(1, 3, 0), 1'b1);
    wait_n(b + 2, 20, "underrun_head");
    for (int i = 0; i < 4; i++) begin
      tick;
      asserts++;
      if (n !== b + 2 || in_rd_en !== '0) begin fails++; $display("FAIL underrun_stall%0d: got %0d words rd_en %b, want 2 0000", i, n - b, in_rd_en); end
    end
    asserts++;
    if (u_dut.state_q !== XFER || u_dut.cur_q !== 2'd0) begin fails++; $display("FAIL underrun_hold: state %0d cur %0d, want XFER 0", u_dut.state_q, u_dut.cur_q); end
    push(0, word(0, 3, 2), 1'b0);
    push(0, word(0, 3, 3), 1'b1);
    wait_n(b + 5, 30, "underrun_tail");
    tick;
    for (int k = 0; k < 5; k++) begin
      asserts++;
      if (lg_data[b+k] !== ((k < 4) ? word(0, 3, k) : word(1, 3, 0)) || lg_src[b+k] !== ((k < 4) ? 2'd0 : 2'd1))
        begin fails++; $display("FAIL underrun_word%0d: got %h src %0d, want %h %0d", k, lg_data[b+k], lg_src[b+k], (k < 4) ? word(0, 3, k) : word(1, 3, 0), (k < 4) ? 0 : 1); end
    end
  endtask

  task automatic test_wrap;
    int b;
    do_reset;
    b = n3;
    push3[1] = push3[1] + 1;
    wait_n3(b + 1, 20, "wrap_q1");
    tick;
    asserts++;
    if (lg3_src[b] !== 2'd1 || u_dut3.rr_ptr_q !== 2'd2) begin fails++; $display("FAIL wrap_setup: src %0d rr_ptr %0d, want 1 2", lg3_src[b], u_dut3.rr_ptr_q); end
    push3[0] = push3[0] + 1;
    push3[2] = push3[2] + 1;
    wait_n3(b + 2, 20, "wrap_q2");
    asserts++;
    if (lg3_src[b+1] !== 2'd2 || lg3_data[b+1] !== DW'(102) || u_dut3.rr_ptr_q !== 2'd0)
      begin fails++; $display("FAIL wrap_q2: src %0d data %0d rr_ptr %0d, want 2 102 0", lg3_src[b+1], lg3_data[b+1], u_dut3.rr_ptr_q); end
    wait_n3(b + 3, 20, "wrap_q0");
    asserts++;
    if (lg3_src[b+2] !== 2'd0 || lg3_data[b+2] !== DW'(100) || u_dut3.rr_ptr_q !== 2'd1)
      begin fails++; $display("FAIL wrap_q0: src %0d data %0d rr_ptr %0d, want 0 100 1", lg3_src[b+2], lg3_data[b+2], u_dut3.rr_ptr_q); end
  endtask

  task automatic test_reset_mid;
    int b;
    do_reset;
    b = n;
    push(2, word(2, 9, 0), 1'b1);
    wait_n(b + 1, 20, "mid_setup");
    for (int w = 0; w < 4; w++) push(1, word(1, 9, w), w == 3);
    wait_n(b + 3, 20, "mid_partial");
    asserts++;
    if (lg_src[b+1] !== 2'd1 || u_dut.rr_ptr_q !== 2'd3) begin fails++; $display("FAIL mid_select: src %0d rr_ptr %0d, want 1 3", lg_src[b+1], u_dut.rr_ptr_q); end
    reset = 1'b1;
    tick;
    asserts += 2;
    if (out_wr !== 1'b0 || in_rd_en !== '0) begin fails++; $display("FAIL mid_outputs: out_wr %b rd_en %b, want 0 0000", out_wr, in_rd_en); end
    if (u_dut.state_q !== IDLE || u_dut.rr_ptr_q !== 2'd0) begin fails++; $display("FAIL mid_state: state %0d rr_ptr %0d, want IDLE 0", u_dut.state_q, u_dut.rr_ptr_q); end
    reset = 1'b0;
    repeat (4) tick;
    asserts++;
    if (n !== b + 3) begin fails++; $display("FAIL mid_abandon: got %0d words, want 3", n - b); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_back_pressure;
    test_underrun;
    test_wrap;
    test_reset_mid;
    asserts++;
    if (bad_pops !== 0) begin fails++; $display("FAIL rd_en_legal: got %0d illegal pops, want 0", bad_pops); end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/fifo_rr_arbiter.md
# fifo_rr_arbiter

Packet-granular round-robin arbiter that drains NUM_QUEUES first-word-fallthrough FIFOs into one shared output stream. It sits between the per-port input FIFOs and the single downstream datapath. It drives each FIFO's read enable directly and forwards complete packets (delimited by an EOP bit) without interleaving. Output is fully registered and throttled by a downstream-ready signal intended to be driven from the next FIFO's ~nearly_full.

## Interface
- NUM_QUEUES, 4, number of input FIFOs (≥2)
- QUEUE_BITS, 2, width of queue index; NUM_QUEUES ≤ 2**QUEUE_BITS
- DATA_WIDTH, 64, width of one data word (EOP carried separately)
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- in_data  input  NUM_QUEUES*DATA_WIDTH  fallthrough dout of each FIFO; queue i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_eop  input  NUM_QUEUES  EOP bit of each FIFO's head word
- in_empty  input  NUM_QUEUES  empty flag of each FIFO
- in_rd_en  output  NUM_QUEUES  pop strobe per FIFO, combinational, at most one bit high
- out_rdy  input  1  downstream can accept a word next cycle
- out_wr  output  1  out_data/out_eop/out_src valid this cycle
- out_data  output  DATA_WIDTH  forwarded word
- out_eop  output  1  last word of packet
- out_src  output  QUEUE_BITS  index of the source queue of this word

## Operation
- States: IDLE, XFER. Registers: state, cur (QUEUE_BITS), rr_ptr (QUEUE_BITS), output registers.
- IDLE: candidate mask = ~in_empty. If mask nonzero, select first set bit searching cyclically from rr_ptr upward (rr_ptr, rr_ptr+1, …, wrap at NUM_QUEUES-1 → 0); cur <= selection; state <= XFER. No pop in IDLE.
- XFER: pop = ~in_empty[cur] & out_rdy. in_rd_en[cur] = pop; all other bits 0.
- On pop: out_wr <= 1, out_data <= in_data[cur], out_eop <= in_eop[cur], out_src <= cur. If in_eop[cur]: state <= IDLE, rr_ptr <= cur+1 (wrap to 0 past NUM_QUEUES-1).
- No pop: out_wr <= 0; out_data/out_eop/out_src hold.
- A packet never interleaves with another; queue empty mid-packet or out_rdy low simply stalls XFER in place.
- Queue index arithmetic modulo NUM_QUEUES, not 2**QUEUE_BITS.

## Timing
- Reset: state=IDLE, cur=0, rr_ptr=0, out_wr=0, out_data=0, out_eop=0, out_src=0; in_rd_en=0 (state is IDLE).
- Reset mid-packet: abandons packet immediately; partial packet not completed. Input FIFOs share the same reset.
- Latency: in_empty[i] falls in cycle t (arbiter idle, rr_ptr=i) → IDLE selects at t, first pop at t+1, out_wr high at t+2.
- Throughput: one word per cycle inside a packet; exactly one bubble cycle (IDLE) between packets.
- Fallthrough contract: head word valid whenever ~in_empty; after a pop, next head and empty flag are valid the following cycle, so back-to-back pops are legal.
- out_rdy sampled in the pop cycle; one registered word may land after out_rdy falls, so out_rdy must deassert with ≥1 free slot (nearly_full).
- EOP on a single-word packet: pop and return to IDLE in the same cycle.

## Structure
- Package fifo_arb_pkg: state encodings (IDLE, XFER), default parameter constants.
- Sub-module rr_priority_select: combinational; inputs mask[NUM_QUEUES], ptr[QUEUE_BITS]; outputs valid, sel[QUEUE_BITS] (first set bit at or cyclically after ptr).
- Top holds FSM, rr_ptr/cur registers, output registers, data mux.

## Test plan
- Single queue: 3-word packet (A,B,C, EOP on C) in queue 2, out_rdy=1 → out_wr high 3 consecutive cycles, data A,B,C, out_src=2, out_eop only on C; rr_ptr=3 afterwards.
- Fairness: queues 0,1,3 each hold two 2-word packets → output order by source 0,1,3,0,1,3; one idle cycle between packets; no interleaving.
- Back-pressure: out_rdy low for 4 cycles mid-packet → no in_rd_en, out_wr low after the stall begins, no word lost or duplicated; resumes next word on out_rdy high.
- Underrun: queue goes empty after word 2 of a 4-word packet while queue 1 is nonempty → arbiter waits on cur, queue 1 not served until EOP forwarded.
- Wrap: NUM_QUEUES=3, rr_ptr=2, queues 0 and 2 nonempty → queue 2 served, then queue 0; rr_ptr wraps to 0 after queue 2 EOP.
- Reset mid-packet → next cycle out_wr=0, in_rd_en=0, state IDLE, rr_ptr=0.
